ddr3_cmd_timer: RTL and testbench

Timing-enforcement stage directly downstream of the DDR3 command FSM. It accepts one command per `ddl_req_i`/`ddl_rdy_o` handshake and holds off each command class until the DDR3 timings are satisfied. It also generates periodic refresh demand on `ddl_ref_o` and drives registered commands onto the DFI command bus. It does not track per-bank state: the FSM only switches bank via IDLE, so one open row is in flight at a time.

---
 rtl/ddr3_cmd_timer.sv | 198 +++++++++++++++++++
 tb/tb_ddr3_cmd_timer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ddr3_cmd_timer.sv
// DDR3 command timing gate: holds each command class until its timing is met, issues refresh demand,
// and registers accepted commands onto the DFI bus. Optional macro: DDR3_REFRESH_POSTPONE_EN.
module ddr3_cmd_timer #(
  parameter int REQID        = 4,
  parameter int DDR_ROW_BITS = 13,
  parameter int T_RCD        = 2,
  parameter int T_RP         = 2,
  parameter int T_RAS        = 4,
  parameter int T_RTP        = 4,
  parameter int T_WR         = 8,
  parameter int T_CCD        = 4,
  parameter int T_WTR        = 8,
  parameter int T_RTW        = 6,
  parameter int T_RFC        = 11,
  parameter int T_MOD        = 12,
  parameter int T_ZQ         = 64,
  parameter int T_REFI       = 780
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    ddl_req_i,
  input  logic                    ddl_seq_i,
  input  logic [2:0]              ddl_cmd_i,
  input  logic [REQID-1:0]        ddl_tid_i,
  input  logic [2:0]              ddl_ba_i,
  input  logic [DDR_ROW_BITS-1:0] ddl_adr_i,
  output logic                    ddl_rdy_o,
  output logic                    ddl_ref_o,
  output logic [2:0]              dfi_cmd_o,
  output logic [2:0]              dfi_ba_o,
  output logic [DDR_ROW_BITS-1:0] dfi_adr_o,
  output logic [REQID-1:0]        dfi_tid_o,
  output logic                    dfi_rd_o,
  output logic                    dfi_wr_o
);

  localparam int CW = 16;
  typedef logic [CW-1:0] cnt_t;

  localparam logic [2:0] C_MODE = 3'b000;
  localparam logic [2:0] C_REFR = 3'b001;
  localparam logic [2:0] C_PREC = 3'b010;
  localparam logic [2:0] C_ACTV = 3'b011;
  localparam logic [2:0] C_WRIT = 3'b100;
  localparam logic [2:0] C_READ = 3'b101;
  localparam logic [2:0] C_ZQCL = 3'b110;
  localparam logic [2:0] C_NOOP = 3'b111;

`ifdef DDR3_REFRESH_POSTPONE_EN
  localparam logic [3:0] PEND_MAX = 4'd8;
`else
  localparam logic [3:0] PEND_MAX = 4'd1;
`endif

  function automatic cnt_t sat_dec(input cnt_t v);
    return (v == '0) ? '0 : v - cnt_t'(1);
  endfunction

  function automatic cnt_t cmax(input cnt_t a, input cnt_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic cnt_t ld(input int n);
    return cnt_t'(n - 1);
  endfunction

  cnt_t act_cnt_q, act_cnt_d, rd_cnt_q, rd_cnt_d;
  cnt_t wr_cnt_q, wr_cnt_d, pre_cnt_q, pre_cnt_d;
  cnt_t refi_cnt_q, refi_cnt_d;
  cnt_t act_lv, rd_lv, wr_lv, pre_lv;
  logic act_ld, rd_ld, wr_ld, pre_ld;
  logic [3:0] pend_q, pend_d;
  logic refr_q, refr_d;
  logic [2:0] cmd_q, cmd_d, ba_q, ba_d;
  logic [DDR_ROW_BITS-1:0] adr_q, adr_d;
  logic [REQID-1:0] tid_q, tid_d;
  logic rd_q, rd_d, wr_q, wr_d;
  logic all_zero, timing_ok, blocked, accept, refr_acc, wrap, is_maint;

  always_comb begin
    all_zero  = (act_cnt_q == '0) && (rd_cnt_q == '0) && (wr_cnt_q == '0) && (pre_cnt_q == '0);
    is_maint  = (ddl_cmd_i == C_REFR) || (ddl_cmd_i == C_NOOP);
    timing_ok = 1'b0;
    case (ddl_cmd_i)
      C_ACTV:  timing_ok = (act_cnt_q == '0);
      C_READ:  timing_ok = (rd_cnt_q == '0);
      C_WRIT:  timing_ok = (wr_cnt_q == '0);
      C_PREC:  timing_ok = (pre_cnt_q == '0);
      C_NOOP:  timing_ok = 1'b1;
      default: timing_ok = all_zero;
    endcase
    // A saturated backlog (8 postponed, or any at all without postponement) admits only REFR/NOOP.
    blocked   = (pend_q == PEND_MAX) && !is_maint;
    ddl_rdy_o = !ddl_req_i || (timing_ok && !blocked);
    accept    = ddl_req_i && ddl_rdy_o;
    refr_acc  = accept && (ddl_cmd_i == C_REFR);

    act_ld = 1'b0; rd_ld = 1'b0; wr_ld = 1'b0; pre_ld = 1'b0;
    act_lv = '0;   rd_lv = '0;   wr_lv = '0;   pre_lv = '0;
    if (accept) begin
      case (ddl_cmd_i)
        C_ACTV: begin
          rd_ld = 1'b1; rd_lv = ld(T_RCD);
          wr_ld = 1'b1; wr_lv = ld(T_RCD);
          pre_ld = 1'b1; pre_lv = ld(T_RAS);
        end
        C_READ: begin
          rd_ld = 1'b1; rd_lv = ld(T_CCD);
          wr_ld = 1'b1; wr_lv = ld(T_RTW);
          pre_ld = 1'b1; pre_lv = ld(T_RTP);
          act_ld = ddl_adr_i[10]; act_lv = ld(T_RTP + T_RP);
        end
        C_WRIT: begin
          wr_ld = 1'b1; wr_lv = ld(T_CCD);
          rd_ld = 1'b1; rd_lv = ld(T_WTR);
          pre_ld = 1'b1; pre_lv = ld(T_WR);
          act_ld = ddl_adr_i[10]; act_lv = ld(T_WR + T_RP);
        end
        C_PREC: begin
          act_ld = 1'b1; act_lv = ld(T_RP);
        end
        C_REFR, C_MODE, C_ZQCL: begin
          act_ld = 1'b1; rd_ld = 1'b1; wr_ld = 1'b1; pre_ld = 1'b1;
          act_lv = (ddl_cmd_i == C_REFR) ? ld(T_RFC) : (ddl_cmd_i == C_MODE) ? ld(T_MOD) : ld(T_ZQ);
          rd_lv = act_lv; wr_lv = act_lv; pre_lv = act_lv;
        end
        default: ;
      endcase
    end
    act_cnt_d = act_ld ? cmax(act_cnt_q, act_lv) : sat_dec(act_cnt_q);
    rd_cnt_d  = rd_ld  ? cmax(rd_cnt_q,  rd_lv)  : sat_dec(rd_cnt_q);
    wr_cnt_d  = wr_ld  ? cmax(wr_cnt_q,  wr_lv)  : sat_dec(wr_cnt_q);
    pre_cnt_d = pre_ld ? cmax(pre_cnt_q, pre_lv) : sat_dec(pre_cnt_q);

    wrap       = (refi_cnt_q == cnt_t'(T_REFI - 1));
    refi_cnt_d = wrap ? '0 : refi_cnt_q + cnt_t'(1);
    pend_d     = pend_q;
    case ({wrap, refr_acc})
      2'b10:   pend_d = (pend_q == PEND_MAX) ? pend_q : pend_q + 4'd1;
      2'b01:   pend_d = (pend_q == 4'd0) ? pend_q : pend_q - 4'd1;
      default: pend_d = pend_q;
    endcase
    // Demand stays up through the refresh itself, dropping one cycle before tRFC expires.
    refr_d    = refr_acc || (refr_q && (act_cnt_q != '0));
    ddl_ref_o = (pend_q != 4'd0) || (refr_q && (act_cnt_q > cnt_t'(1)));

    cmd_d = accept ? ddl_cmd_i : C_NOOP;
    ba_d  = accept ? ddl_ba_i  : ba_q;
    adr_d = accept ? ddl_adr_i : adr_q;
    tid_d = accept ? ddl_tid_i : tid_q;
    rd_d  = accept && (ddl_cmd_i == C_READ);
    wr_d  = accept && (ddl_cmd_i == C_WRIT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      act_cnt_q  <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      pre_cnt_q  <= '0;
      refi_cnt_q <= '0;
      pend_q     <= '0;
      refr_q     <= 1'b0;
      cmd_q      <= C_NOOP;
      ba_q       <= '0;
      adr_q      <= '0;
      tid_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      act_cnt_q  <= act_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      pre_cnt_q  <= pre_cnt_d;
      refi_cnt_q <= refi_cnt_d;
      pend_q     <= pend_d;
      refr_q     <= refr_d;
      cmd_q      <= cmd_d;
      ba_q       <= ba_d;
      adr_q      <= adr_d;
      tid_q      <= tid_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  assign dfi_cmd_o = cmd_q;
  assign dfi_ba_o  = ba_q;
  assign dfi_adr_o = adr_q;
  assign dfi_tid_o = tid_q;
  assign dfi_rd_o  = rd_q;
  assign dfi_wr_o  = wr_q;

  // Sequencing hint carries no timing meaning here.
  logic seq_unused;
  assign seq_unused = ddl_seq_i;

endmodule

// File: tb/tb_ddr3_cmd_timer.sv
// Scoreboard bench for ddr3_cmd_timer: directed commands with hand-derived accept cycles;
// a monitor pops expected DFI beats whenever the DUT drives a command.
module tb_ddr3_cmd_timer;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        req, seq;
  logic [2:0]  cmd, ba;
  logic [3:0]  tid;
  logic [12:0] adr;
  logic        rdy, ref_o, rd_o, wr_o;
  logic [2:0]  dcmd, dba;
  logic [12:0] dadr;
  logic [3:0]  dtid;

  localparam logic [2:0] REFR = 3'b001, ACTV = 3'b011, WRIT = 3'b100, READ = 3'b101;

  ddr3_cmd_timer dut (
    .clock(clock), .reset_n(reset_n), .ddl_req_i(req), .ddl_seq_i(seq), .ddl_cmd_i(cmd),
    .ddl_tid_i(tid), .ddl_ba_i(ba), .ddl_adr_i(adr), .ddl_rdy_o(rdy), .ddl_ref_o(ref_o),
    .dfi_cmd_o(dcmd), .dfi_ba_o(dba), .dfi_adr_o(dadr), .dfi_tid_o(dtid),
    .dfi_rd_o(rd_o), .dfi_wr_o(wr_o)
  );

  always #5 clock = ~clock;

  int cyc;
  always @(posedge clock) cyc <= reset_n ? cyc + 1 : 0;

  typedef struct {
    logic [2:0]  cmd;
    logic [2:0]  ba;
    logic [12:0] adr;
    logic [3:0]  tid;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Caller is just after a rising edge; returns just after the edge following the accept.
  task automatic send(input logic [2:0] c, input logic [2:0] b, input logic [12:0] a,
                      input logic [3:0] t, output int acc);
    exp_t e;
    acc = -1;
    req = 1'b1; cmd = c; ba = b; adr = a; tid = t; seq = ~seq;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (rdy) begin
        acc = cyc;
        e.cmd = c; e.ba = b; e.adr = a; e.tid = t; e.cyc = cyc + 1;
        sb.push_back(e);
        @(posedge clock); #1;
        break;
      end
      @(posedge clock); #1;
    end
    req = 1'b0; cmd = 3'b111;
  endtask

  task automatic hold(input logic [2:0] c, input int n, input string nm);
    int bad = 0;
    req = 1'b1; cmd = c; ba = 3'd0; adr = 13'd0; tid = 4'd0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (rdy) bad++;
      @(posedge clock); #1;
    end
    req = 1'b0; cmd = 3'b111;
    chk(nm, bad, 0);
  endtask

  always @(negedge clock) begin
    if (reset_n && (dcmd != 3'b111 || rd_o || wr_o)) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL dfi_unexpected: got cmd %0d rd %0d wr %0d expected none (cycle %0d)",
                 dcmd, rd_o, wr_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("dfi_cycle", cyc, e.cyc);
        chk("dfi_cmd", dcmd, e.cmd);
        chk("dfi_ba", dba, e.ba);
        chk("dfi_adr", dadr, e.adr);
        chk("dfi_tid", dtid, e.tid);
        chk("dfi_rd", rd_o, e.cmd == READ);
        chk("dfi_wr", wr_o, e.cmd == WRIT);
      end
    end
  end

  int ta, tr, tr2, tw, tr3, tw2, ta2, tref, tf, tfall, ta3, tref2, tx, ty;

  initial begin
    reset_n = 1'b0; req = 1'b0; seq = 1'b0; cmd = 3'b111; ba = '0; adr = '0; tid = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("rst_rdy", rdy, 1);
    chk("rst_cmd", dcmd, 7);
    chk("rst_ref", ref_o, 0);
    chk("rst_rd", rd_o, 0);
    chk("rst_wr", wr_o, 0);
    chk("rst_adr", dadr, 0);
    @(posedge clock); #1;

    send(ACTV, 3'd2, 13'h0155, 4'd1, ta);
    send(READ, 3'd2, 13'h0010, 4'd2, tr);   chk("act_to_rd", tr, ta + 2);
    send(READ, 3'd2, 13'h0018, 4'd3, tr2);  chk("rd_to_rd", tr2, tr + 4);
    send(WRIT, 3'd2, 13'h0020, 4'd4, tw);   chk("rd_to_wr", tw, tr2 + 6);
    send(READ, 3'd2, 13'h0028, 4'd5, tr3);  chk("wr_to_rd", tr3, tw + 8);
    send(WRIT, 3'd2, 13'h0430, 4'd6, tw2);  chk("rd_to_wrap", tw2, tr3 + 6);
    send(ACTV, 3'd5, 13'h0abc, 4'd7, ta2);  chk("wrap_to_act", ta2, tw2 + 10);

    tref = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (ref_o) begin tref = cyc; break; end
    end
    chk("refi_first", tref, 780);
    @(posedge clock); #1;
    send(REFR, 3'd0, 13'h0000, 4'd8, tf);   chk("refr_acc", tf, 781);
    tfall = -1;
    fork
      begin
        for (int i = 0; i < 50; i++) begin
          @(negedge clock);
          if (!ref_o) begin tfall = cyc; break; end
        end
      end
      send(ACTV, 3'd1, 13'h0123, 4'd9, ta3);
    join
    chk("ref_fall", tfall, tf + 10);
    chk("refr_to_act", ta3, tf + 11);

    tref2 = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (ref_o) begin tref2 = cyc; break; end
    end
    chk("refi_second", tref2, 1560);
    @(posedge clock); #1;
`ifdef DDR3_REFRESH_POSTPONE_EN
    send(ACTV, 3'd3, 13'h0777, 4'd10, tx);  chk("postpone_act", tx, 1561);
    do begin @(posedge clock); #1; end while (cyc < 7019);
    send(ACTV, 3'd4, 13'h0111, 4'd11, tx);  chk("pend7_act", tx, 7019);
    hold(ACTV, 20, "pend8_block");
    send(REFR, 3'd0, 13'h0000, 4'd12, ty);  chk("pend8_refr", ty, 7040);
    send(ACTV, 3'd6, 13'h0222, 4'd13, tx);  chk("pend7_refr_act", tx, ty + 11);
`else
    hold(ACTV, 20, "pend_block");
    send(REFR, 3'd0, 13'h0000, 4'd12, ty);  chk("pend_refr", ty, 1581);
    send(ACTV, 3'd6, 13'h0222, 4'd13, tx);  chk("pend_refr_act", tx, ty + 11);
`endif

    repeat (4) @(posedge clock);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
